riscv_arb_mux: RTL and testbench
================================

# riscv_arb_mux

Registered N-channel arbitrating multiplexer: the handshaked, sequential successor to the combinational `riscv_mux`. Each of `N_MUX_IN` sources presents `XLEN`-bit data with valid/ready. A round-robin or fixed-priority arbiter picks one source per cycle, and the winner's word is captured into a single output register with its own valid/ready. It sits in front of shared RV32I resources, for example the IF/MEM ports onto one memory bus or several writers onto one register-file write port.

## Interface
Parameters:
- `N_MUX_IN`, 3, number of input channels; legal range 2..16.
- `XLEN`, `` `XLEN `` (32), data width per channel.

Ports:
- `i_clk`  in  1  clock; all state on the rising edge.
- `i_rst`  in  1  reset; asynchronous, active-high.
- `i_mux_concat_data`  in  N_MUX_IN*XLEN  channel k occupies bits [k*XLEN +: XLEN].
- `i_mux_valid`  in  N_MUX_IN  per-channel request.
- `o_mux_ready`  out  N_MUX_IN  one-hot or zero; the channel is accepted this cycle.
- `i_mux_mode`  in  1  0 = round-robin, 1 = fixed priority (lowest index wins).
- `o_mux_data`  out  XLEN  registered output word.
- `o_mux_sel`  out  $clog2(N_MUX_IN)  source index of `o_mux_data`.
- `o_mux_valid`  out  1  output register holds a word.
- `i_mux_ready`  in  1  downstream consumes the word when it is high together with `o_mux_valid`.

## Operation
- Load condition: `load = ~o_mux_valid | i_mux_ready`.
- Grant: when `load` is high and any valid is set, exactly one `o_mux_ready[g]` is 1 and the others are 0. When `load` is low or no input is valid, all `o_mux_ready` bits are 0. `o_mux_ready[g]` is only ever asserted when `i_mux_valid[g]` is also high.
- Round-robin mode:
  - Search starts at `rr_ptr` and walks ascending indices modulo `N_MUX_IN`.
  - After a grant to g, `rr_ptr` becomes g+1, or 0 if g = N_MUX_IN-1. Wrap is explicit, so a non-power-of-2 N never points at an illegal index.
- Fixed mode: the search starts at index 0 and `rr_ptr` holds its value.
- A mode change takes effect on the first arbitration after `i_mux_mode` changes; there is no flush.
- On a grant, the next edge loads `o_mux_data` with channel g's data, sets `o_mux_sel` = g and sets `o_mux_valid` = 1.
- If `load` is high and there is no request, `o_mux_valid` goes to 0 at the next edge, and `o_mux_data`/`o_mux_sel` hold their values.
- Sources keep valid and data stable until they are accepted; the block does not check this.

## Timing
- Reset values (applied immediately while `i_rst` = 1): `o_mux_valid` = 0, `o_mux_data` = 0, `o_mux_sel` = 0, `rr_ptr` = 0, all `o_mux_ready` = 0 (forced combinationally).
- Latency: 1 cycle from accept (`o_mux_ready[g]` & `i_mux_valid[g]`) to `o_mux_valid`.
- Throughput: 1 word per cycle when `i_mux_ready` is held at 1.
- `o_mux_ready` is combinational from `i_mux_valid`, `i_mux_ready`, `i_mux_mode` and `rr_ptr`.
- Consume and refill happen in the same edge: when `o_mux_valid` & `i_mux_ready` are high and a request is present, the new word replaces the old one with no bubble.
- Backpressure: while `o_mux_valid` = 1 and `i_mux_ready` = 0, `o_mux_data`/`o_mux_sel` stay stable and no grant is issued.
- If reset asserts mid-transfer, the in-flight word is dropped. The first grant after deassertion searches from index 0.

## Structure
- Shared header `riscv_configs.v` holds `` `XLEN `` and the mode encodings `` `MUX_MODE_RR `` = 1'b0 and `` `MUX_MODE_FIX `` = 1'b1.
- Sub-module `riscv_rr_arbiter`:
  - Parameters: `N_MUX_IN`.
  - Inputs: request vector, start index, enable.
  - Outputs: one-hot grant, grant index, any-grant.
  - The top level owns `rr_ptr`, the output register, and a data select implemented by indexing `i_mux_concat_data` with the grant index.

## Test plan
All scenarios use `N_MUX_IN` = 3, `XLEN` = 32, and data ch0 = 0x11111111, ch1 = 0x22222222, ch2 = 0x33333333.
1. Assert `i_rst` mid-stream while `o_mux_valid` = 1 → in the same cycle `o_mux_valid` = 0, `o_mux_data` = 0, `o_mux_sel` = 0, `o_mux_ready` = 3'b000.
2. Round-robin, all valid, `i_mux_ready` = 1 → `o_mux_sel` runs 0,1,2,0,1,2 on consecutive cycles starting 1 cycle after the first grant, with matching data.
3. Fixed mode, all valid → `o_mux_sel` = 0 every cycle, `o_mux_ready` = 3'b001, ch1 and ch2 never accepted.
4. Output valid, then `i_mux_ready` = 0 for 5 cycles → `o_mux_data`/`o_mux_sel` stable and `o_mux_ready` = 0. On the release cycle, a new grant issues and the next word appears 1 cycle later.
5. Wrap: `rr_ptr` = 2, only ch0 and ch2 valid → grants go ch2 then ch0 (`rr_ptr` wraps 2→0→1). The next search skips ch1 and grants ch2.
6. Idle block, single-cycle `i_mux_valid` = 3'b010 → `o_mux_ready` = 3'b010 in that cycle. Next cycle `o_mux_valid` = 1, `o_mux_data` = 0x22222222, `o_mux_sel` = 1. It drops to 0 after consumption with no further requests.

Source files
------------

// File: rtl/riscv_arb_mux_pkg.sv
// Shared constants and helpers for the registered arbitrating multiplexer.
// The mode encodings match the ones riscv_mux users already select with.
package riscv_arb_mux_pkg;

    localparam int   DEF_XLEN     = 32;
    localparam logic MUX_MODE_RR  = 1'b0;
    localparam logic MUX_MODE_FIX = 1'b1;

    // Increment with an explicit wrap, so a non-power-of-2 N never
    // produces an out-of-range index.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/riscv_rr_arbiter.sv
// Rotating-start arbiter: grants the first requester found walking upward
// from start_i, modulo N_MUX_IN. The grant is zero while en_i is low.
module riscv_rr_arbiter #(
    parameter int N_MUX_IN = 3,
    localparam int SW      = (N_MUX_IN > 1) ? $clog2(N_MUX_IN) : 1
) (
    input  logic [N_MUX_IN-1:0] req_i,
    input  logic [SW-1:0]       start_i,
    input  logic                en_i,
    output logic [N_MUX_IN-1:0] gnt_o,
    output logic [SW-1:0]       gnt_idx_o,
    output logic                any_o
);

    always_comb begin
        int k;
        k         = 0;
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_o     = 1'b0;
        if (en_i) begin
            for (int off = 0; off < N_MUX_IN; off++) begin
                k = int'(start_i) + off;
                if (k >= N_MUX_IN) k = k - N_MUX_IN;
                if (!any_o && req_i[k]) begin
                    any_o     = 1'b1;
                    gnt_o[k]  = 1'b1;
                    gnt_idx_o = SW'(k);
                end
            end
        end
    end

endmodule

// File: rtl/riscv_arb_mux.sv
// N-channel valid/ready multiplexer: round-robin or fixed-priority arbiter
// feeding a single output register.
module riscv_arb_mux
    import riscv_arb_mux_pkg::*;
#(
    parameter int  N_MUX_IN = 3,
    parameter int  XLEN     = DEF_XLEN,
    localparam int SW       = (N_MUX_IN > 1) ? $clog2(N_MUX_IN) : 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [N_MUX_IN*XLEN-1:0] i_mux_concat_data,
    input  logic [N_MUX_IN-1:0]      i_mux_valid,
    output logic [N_MUX_IN-1:0]      o_mux_ready,
    input  logic                     i_mux_mode,
    output logic [XLEN-1:0]          o_mux_data,
    output logic [SW-1:0]            o_mux_sel,
    output logic                     o_mux_valid,
    input  logic                     i_mux_ready
);

    logic                load;
    logic [SW-1:0]       start;
    logic [N_MUX_IN-1:0] gnt;
    logic [SW-1:0]       gnt_idx;
    logic                any_gnt;

    logic [SW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [XLEN-1:0] data_q, data_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic            valid_q, valid_d;

    // Empty register or a word leaving this edge: a new word may enter.
    assign load  = ~valid_q | i_mux_ready;
    assign start = (i_mux_mode == MUX_MODE_FIX) ? '0 : rr_ptr_q;

    riscv_rr_arbiter #(.N_MUX_IN(N_MUX_IN)) u_arb (
        .req_i    (i_mux_valid),
        .start_i  (start),
        .en_i     (load & ~i_rst),
        .gnt_o    (gnt),
        .gnt_idx_o(gnt_idx),
        .any_o    (any_gnt)
    );

    assign o_mux_ready = gnt;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        data_d   = data_q;
        sel_d    = sel_q;
        valid_d  = valid_q;
        if (any_gnt) begin
            data_d  = i_mux_concat_data[int'(gnt_idx)*XLEN +: XLEN];
            sel_d   = gnt_idx;
            valid_d = 1'b1;
            if (i_mux_mode == MUX_MODE_RR)
                rr_ptr_d = SW'(wrap_inc(int'(gnt_idx), N_MUX_IN));
        end else if (load) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rr_ptr_q <= '0;
            data_q   <= '0;
            sel_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            data_q   <= data_d;
            sel_q    <= sel_d;
            valid_q  <= valid_d;
        end
    end

    assign o_mux_data  = data_q;
    assign o_mux_sel   = sel_q;
    assign o_mux_valid = valid_q;

endmodule

// File: tb/tb_riscv_arb_mux.sv
// Directed vector table for the documented scenarios, then random traffic
// compared against a queue-free behavioural model of the arbiter.
module tb_riscv_arb_mux;

    localparam int N  = 3;
    localparam int XL = 32;

    logic            i_clk = 1'b0;
    logic            i_rst = 1'b1;
    logic [N*XL-1:0] i_mux_concat_data;
    logic [N-1:0]    i_mux_valid = '0;
    logic [N-1:0]    o_mux_ready;
    logic            i_mux_mode = 1'b0;
    logic [XL-1:0]   o_mux_data;
    logic [1:0]      o_mux_sel;
    logic            o_mux_valid;
    logic            i_mux_ready = 1'b1;

    riscv_arb_mux #(.N_MUX_IN(N), .XLEN(XL)) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_mux_concat_data(i_mux_concat_data),
        .i_mux_valid      (i_mux_valid),
        .o_mux_ready      (o_mux_ready),
        .i_mux_mode       (i_mux_mode),
        .o_mux_data       (o_mux_data),
        .o_mux_sel        (o_mux_sel),
        .o_mux_valid      (o_mux_valid),
        .i_mux_ready      (i_mux_ready)
    );

    always #5 i_clk = ~i_clk;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reference model: output register contents and the round-robin pointer.
    bit          m_v;
    logic [31:0] m_d;
    int          m_sel, m_ptr;
    int          m_g;

    task automatic model_reset();
        m_v = 0; m_d = 0; m_sel = 0; m_ptr = 0;
    endtask

    function automatic int pick(input logic [N-1:0] v, input logic r, input logic m,
                                input bit cur_v, input int ptr);
        int first;
        if (cur_v && !r) return -1;
        first = m ? 0 : ptr;
        for (int off = 0; off < N; off++)
            if (v[(first + off) % N]) return (first + off) % N;
        return -1;
    endfunction

    // One cycle: drive, sample the combinational grant, clock, advance model.
    logic [N-1:0] rdy_seen;
    task automatic step(input logic [N-1:0] v, input logic r, input logic m);
        logic [31:0] dsel;
        i_mux_valid = v; i_mux_ready = r; i_mux_mode = m;
        #1;
        rdy_seen = o_mux_ready;
        m_g = pick(v, r, m, m_v, m_ptr);
        @(posedge i_clk);
        if (m_g >= 0) begin
            dsel  = i_mux_concat_data[m_g*XL +: XL];
            m_v   = 1; m_d = dsel; m_sel = m_g;
            if (!m) m_ptr = (m_g + 1) % N;
        end else if (!m_v || r) begin
            m_v = 0;
        end
        #1;
    endtask

    typedef struct {
        logic [2:0] v;
        logic       r;
        logic       m;
        logic [2:0] er;
        logic       ev;
        logic [1:0] es;
    } vec_t;
    vec_t tbl[$];

    initial begin
        logic [N-1:0] exp_r;
        // idle single request on ch1, then drain
        tbl.push_back('{3'b010, 1'b1, 1'b0, 3'b010, 1'b1, 2'd1});
        tbl.push_back('{3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 2'd1});
        // wrap with ch0/ch2 only, pointer starts at 2
        tbl.push_back('{3'b101, 1'b1, 1'b0, 3'b100, 1'b1, 2'd2});
        tbl.push_back('{3'b101, 1'b1, 1'b0, 3'b001, 1'b1, 2'd0});
        tbl.push_back('{3'b101, 1'b1, 1'b0, 3'b100, 1'b1, 2'd2});
        // round-robin, all valid
        for (int i = 0; i < 6; i++)
            tbl.push_back('{3'b111, 1'b1, 1'b0, 3'(1 << (i % 3)), 1'b1, 2'(i % 3)});
        // fixed priority
        for (int i = 0; i < 3; i++)
            tbl.push_back('{3'b111, 1'b1, 1'b1, 3'b001, 1'b1, 2'd0});
        tbl.push_back('{3'b111, 1'b1, 1'b0, 3'b001, 1'b1, 2'd0});
        // backpressure, then release
        for (int i = 0; i < 5; i++)
            tbl.push_back('{3'b111, 1'b0, 1'b0, 3'b000, 1'b1, 2'd0});
        tbl.push_back('{3'b111, 1'b1, 1'b0, 3'b010, 1'b1, 2'd1});

        i_mux_concat_data = {32'h33333333, 32'h22222222, 32'h11111111};
        model_reset();
        @(posedge i_clk); @(posedge i_clk); #1;
        chk("reset_valid", 32'(o_mux_valid), 0);
        chk("reset_data",  o_mux_data, 0);
        chk("reset_sel",   32'(o_mux_sel), 0);
        chk("reset_ready", 32'(o_mux_ready), 0);
        i_rst = 1'b0;

        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].r, tbl[i].m);
            chk($sformatf("vec%0d_ready", i), 32'(rdy_seen), 32'(tbl[i].er));
            chk($sformatf("vec%0d_valid", i), 32'(o_mux_valid), 32'(tbl[i].ev));
            chk($sformatf("vec%0d_sel", i), 32'(o_mux_sel), 32'(tbl[i].es));
            chk($sformatf("vec%0d_data", i), o_mux_data, 32'h11111111 * (32'(tbl[i].es) + 1));
        end

        // reset while a word is held: outputs clear without a clock edge
        i_mux_valid = 3'b111; i_mux_ready = 1'b1;
        i_rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(o_mux_valid), 0);
        chk("midrst_data",  o_mux_data, 0);
        chk("midrst_sel",   32'(o_mux_sel), 0);
        chk("midrst_ready", 32'(o_mux_ready), 0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        model_reset();
        // pointer was 2 before reset; search must restart at 0
        step(3'b111, 1'b1, 1'b0);
        chk("postrst_ready", 32'(rdy_seen), 32'b001);
        chk("postrst_sel", 32'(o_mux_sel), 0);
        chk("postrst_data", o_mux_data, 32'h11111111);

        for (int c = 0; c < 400; c++) begin
            logic [N-1:0] v;
            logic r, m;
            i_mux_concat_data = {$urandom, $urandom, $urandom};
            v = N'($urandom);
            r = ($urandom_range(0, 3) != 0);
            m = ($urandom_range(0, 9) == 0) ? ~i_mux_mode : i_mux_mode;
            step(v, r, m);
            exp_r = (m_g >= 0) ? N'(1 << m_g) : '0;
            chk($sformatf("rnd%0d_ready", c), 32'(rdy_seen), 32'(exp_r));
            chk($sformatf("rnd%0d_valid", c), 32'(o_mux_valid), 32'(m_v));
            chk($sformatf("rnd%0d_sel", c), 32'(o_mux_sel), 32'(m_sel));
            chk($sformatf("rnd%0d_data", c), o_mux_data, m_d);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
